// File: rtl/nios_mult_seq.sv
// Multi-cycle 32x32 multiply sequencer driving the three-partial-product Nios II multiplier cell.
// Optional macro MULT_SEQ_SIGNED_EN enables signed high-word corrections for MULXSS/MULXSU.
module nios_mult_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE1,
        WAIT1,
        ISSUE2,
        WAIT2,
        RESP
    } state_t;

    state_t      state, state_next;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic [2:0]  cnt_q;
    logic [16:0] mid_hi_q;
    logic        lo_carry_q;
    logic [31:0] resp_data_q;

    logic        cnt_last;
    logic [32:0] mid;
    logic [32:0] lo_sum;
    logic [31:0] hi_u;
    logic [31:0] hi_result;

    assign cnt_last = (cnt_q == 3'(CELL_LATENCY - 1));

    // First pass: cross terms are summed, their low half folds into the low word.
    assign mid    = {1'b0, cell_p2} + {1'b0, cell_p3};
    assign lo_sum = {1'b0, cell_p1} + {1'b0, mid[15:0], 16'h0};

    // Second pass: cell_p1 now carries a_hi*b_hi.
    assign hi_u = cell_p1 + {15'h0, mid_hi_q} + {31'h0, lo_carry_q};

`ifdef MULT_SEQ_SIGNED_EN
    logic [31:0] corr_a, corr_b;
    assign corr_a = a_q[31] ? b_q : 32'h0;
    assign corr_b = b_q[31] ? a_q : 32'h0;

    always_comb begin
        hi_result = hi_u;
        case (op_q)
            2'b10:   hi_result = hi_u - corr_a - corr_b;
            2'b11:   hi_result = hi_u - corr_a;
            default: hi_result = hi_u;
        endcase
    end
`else
    assign hi_result = hi_u;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            op_q        <= 2'b00;
            cnt_q       <= 3'h0;
            mid_hi_q    <= 17'h0;
            lo_carry_q  <= 1'b0;
            resp_data_q <= 32'h0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                a_q  <= req_a;
                b_q  <= req_b;
                op_q <= req_op;
            end
            if (state == WAIT1 || state == WAIT2) begin
                cnt_q <= cnt_q + 3'h1;
            end else begin
                cnt_q <= 3'h0;
            end
            if (state == WAIT1 && cnt_last) begin
                mid_hi_q   <= mid[32:16];
                lo_carry_q <= lo_sum[32];
                if (op_q == 2'b00) begin
                    resp_data_q <= lo_sum[31:0];
                end
            end
            if (state == WAIT2 && cnt_last) begin
                resp_data_q <= hi_result;
            end
        end
    end

    always_comb begin
        state_next = state;
        cell_en    = 1'b0;
        cell_src1  = 32'h0;
        cell_src2  = 32'h0;
        case (state)
            IDLE: begin
                if (req_valid) state_next = ISSUE1;
            end
            ISSUE1: begin
                cell_en    = 1'b1;
                cell_src1  = a_q;
                cell_src2  = b_q;
                state_next = WAIT1;
            end
            WAIT1: begin
                cell_en   = 1'b1;
                cell_src1 = a_q;
                cell_src2 = b_q;
                if (cnt_last) state_next = (op_q == 2'b00) ? RESP : ISSUE2;
            end
            ISSUE2: begin
                cell_en    = 1'b1;
                cell_src1  = {16'h0, a_q[31:16]};
                cell_src2  = {16'h0, b_q[31:16]};
                state_next = WAIT2;
            end
            WAIT2: begin
                cell_en   = 1'b1;
                cell_src1 = {16'h0, a_q[31:16]};
                cell_src2 = {16'h0, b_q[31:16]};
                if (cnt_last) state_next = RESP;
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_nios_mult_seq.sv
// Self-checking bench for nios_mult_seq with a behavioural multiplier cell and a result scoreboard.
// Honours MULT_SEQ_SIGNED_EN for the signed high-word expectations.
module tb_nios_mult_seq;

    localparam int LAT     = 1;
    localparam int LAT_LO  = 2 + LAT;
    localparam int LAT_HI  = 3 + 2 * LAT;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [31:0] cell_src1, cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1, cell_p2, cell_p3;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    nios_mult_seq #(.CELL_LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_a(req_a),
        .req_b(req_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .cell_src1(cell_src1),
        .cell_src2(cell_src2),
        .cell_en(cell_en),
        .cell_p1(cell_p1),
        .cell_p2(cell_p2),
        .cell_p3(cell_p3),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural cell: LAT-deep pipeline that only advances while enabled.
    logic [31:0] pipe_p1 [LAT];
    logic [31:0] pipe_p2 [LAT];
    logic [31:0] pipe_p3 [LAT];

    always @(posedge clk) begin
        if (cell_en === 1'b1) begin
            pipe_p1[0] <= 32'(cell_src1[15:0] * cell_src2[15:0]);
            pipe_p2[0] <= 32'(cell_src1[15:0] * cell_src2[31:16]);
            pipe_p3[0] <= 32'(cell_src1[31:16] * cell_src2[15:0]);
            for (int i = 1; i < LAT; i++) begin
                pipe_p1[i] <= pipe_p1[i-1];
                pipe_p2[i] <= pipe_p2[i-1];
                pipe_p3[i] <= pipe_p3[i-1];
            end
        end
    end

    assign cell_p1 = pipe_p1[LAT-1];
    assign cell_p2 = pipe_p2[LAT-1];
    assign cell_p3 = pipe_p3[LAT-1];

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [63:0] ua, ub, sa, sb_ext;
        ua     = {32'h0, a};
        ub     = {32'h0, b};
        sa     = {{32{a[31]}}, a};
        sb_ext = {{32{b[31]}}, b};
        p      = ua * ub;
`ifdef MULT_SEQ_SIGNED_EN
        if (op == 2'b10) p = sa * sb_ext;
        if (op == 2'b11) p = sa * ub;
`endif
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic wait_resp(input string tag, input int exp_lat, input int already);
        int cycles;
        logic [31:0] exp_data;
        cycles = already;
        while (resp_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check_output({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        exp_data = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check_output({tag, "_data"}, resp_data, exp_data);
    endtask

    task automatic complete_resp(input string tag);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_output({tag, "_done_valid"}, {31'h0, resp_valid}, 32'h0);
        check_output({tag, "_done_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    task automatic apply_stimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] expected);
        check_output({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        sb.push_back(expected);
        @(negedge clk);
        req_valid = 1'b0;
        check_output({tag, "_issue_src1"}, cell_src1, a);
        check_output({tag, "_issue_en"}, {31'h0, cell_en}, 32'h1);
        wait_resp(tag, (op == 2'b00) ? LAT_LO : LAT_HI, 1);
        complete_resp(tag);
    endtask

    initial begin
        logic        seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = 32'h0;
        req_b      = 32'h0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check_output("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check_output("rst_resp_data", resp_data, 32'h0);
        check_output("rst_cell_en", {31'h0, cell_en}, 32'h0);
        check_output("rst_cell_src1", cell_src1, 32'h0);
        check_output("rst_busy", {31'h0, busy}, 32'h0);

        apply_stimulus("mul", 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
        apply_stimulus("mulxuu_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        apply_stimulus("mulxuu_carry", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
`ifdef MULT_SEQ_SIGNED_EN
        apply_stimulus("mulxss", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        apply_stimulus("mulxsu", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
`else
        apply_stimulus("mulxss", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        apply_stimulus("mulxsu", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
`endif

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            apply_stimulus("random", rop, ra, rb, model(rop, ra, rb));
        end

        // Backpressure, then a request waiting while the response completes.
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'h0001_0003;
        req_b     = 32'h0002_0005;
        sb.push_back(32'h000B_000F);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp("bp", LAT_LO, 1);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'hFFFF_FFFF;
        req_b     = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("bp_hold_data", resp_data, 32'h000B_000F);
            check_output("bp_hold_valid", {31'h0, resp_valid}, 32'h1);
            check_output("bp_hold_req_ready", {31'h0, req_ready}, 32'h0);
            check_output("bp_hold_cell_en", {31'h0, cell_en}, 32'h0);
        end
        complete_resp("bp");
        sb.push_back(32'hFFFF_FFFE);
        @(negedge clk);
        req_valid = 1'b0;
        check_output("bp_next_busy", {31'h0, busy}, 32'h1);
        wait_resp("bp_next", LAT_HI, 1);
        complete_resp("bp_next");

        // Reset while the first pass is in the cell.
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'h1234_5678;
        req_b     = 32'h9ABC_DEF0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_output("rst_mid_in_wait1", {31'h0, cell_en}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
        check_output("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
        check_output("rst_mid_busy", {31'h0, busy}, 32'h0);
        seen       = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        resp_ready = 1'b0;
        check_output("rst_mid_no_resp", {31'h0, seen}, 32'h0);

        apply_stimulus("after_rst", 2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
